data_memory_hs: RTL

Parametrised byte-addressed data memory for the 32-bit RISC-V pipeline MEM stage. It replaces the always-ready word-indexed array with a valid/ready request/response interface, which adds:
- configurable wait states,
- RV32I byte/halfword/word loads and stores with sign/zero extension,
- misalignment and out-of-range fault reporting.

The pipeline stalls on req_ready/rsp_valid.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_lane_align.sv | 87 ++++++++
 rtl/data_memory_hs.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the handshaked data memory:
//   - RV32I load/store width codes (funct3)
//   - FSM state encoding used by data_memory_hs
//   - word-index width helper for a power-of-two word depth
// -----------------------------------------------------------------------------
package dmem_pkg;

  // RV32I funct3 width codes. Stores only use B/H/W.
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  // Word-index width for a given word depth.
  function automatic int word_idx_w(input int depth_words);
    return $clog2(depth_words);
  endfunction

  localparam int DEPTH_WORDS_DEF = 1024;
  localparam int WORD_IDX_W      = word_idx_w(DEPTH_WORDS_DEF);

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane logic for RV32I loads and stores.
//   i_we        1 = store, 0 = load
//   i_funct3    RV32I width code
//   i_lane      byte offset within the word (addr[1:0])
//   i_wdata     right-aligned store data
//   i_old_word  current contents of the addressed word
//   o_be        byte enables for a store (all zero for loads)
//   o_wword     old word with the enabled lanes replaced by store data
//   o_rdata     extended load result extracted from i_old_word
//   o_misalign  access not naturally aligned for its width
//   o_illegal   funct3 not defined for this access direction
// -----------------------------------------------------------------------------
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_old_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_wword,
  output logic [31:0] o_rdata,
  output logic        o_misalign,
  output logic        o_illegal
);

  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;
  logic [31:0]        w_wrep;
  logic [3:0]         w_be_raw;

  // Little-endian lane extraction from the addressed word.
  assign w_byte = i_old_word[{i_lane, 3'b000} +: 8];
  assign w_half = i_lane[1] ? i_old_word[31:16] : i_old_word[15:0];

  always_comb begin
    w_be_raw   = 4'b0000;
    w_wrep     = i_wdata;
    o_rdata    = 32'd0;
    o_misalign = 1'b0;
    o_illegal  = 1'b0;
    case (i_funct3)
      F3_B: begin
        w_be_raw = 4'b0001 << i_lane;
        w_wrep   = {4{i_wdata[7:0]}};
        o_rdata  = 32'(w_byte);
      end
      F3_H: begin
        o_misalign = i_lane[0];
        w_be_raw   = i_lane[1] ? 4'b1100 : 4'b0011;
        w_wrep     = {2{i_wdata[15:0]}};
        o_rdata    = 32'(w_half);
      end
      F3_W: begin
        o_misalign = (i_lane != 2'b00);
        w_be_raw   = 4'b1111;
        o_rdata    = i_old_word;
      end
      F3_BU: begin
        o_illegal = i_we;
        o_rdata   = {24'd0, w_byte};
      end
      F3_HU: begin
        o_illegal  = i_we;
        o_misalign = i_lane[0];
        o_rdata    = {16'd0, w_half};
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

  assign o_be = i_we ? w_be_raw : 4'b0000;

  // Enabled lanes take the replicated store data; others keep the old byte.
  always_comb begin
    o_wword = i_old_word;
    for (int b = 0; b < 4; b++) begin
      if (o_be[b]) o_wword[8*b +: 8] = w_wrep[8*b +: 8];
    end
  end

endmodule

// File: rtl/data_memory_hs.sv
// -----------------------------------------------------------------------------
// data_memory_hs
// Byte-addressed data memory for the RV32I MEM stage with valid/ready request
// and response channels, optional wait states and fault reporting.
//   clk         clock, all state on the rising edge
//   rst         asynchronous active-high reset
//   req_valid   request present
//   req_ready   request can be accepted this cycle (IDLE and not in reset)
//   req_we      1 = store, 0 = load
//   req_funct3  RV32I width code
//   req_addr    byte address
//   req_wdata   right-aligned store data
//   rsp_valid   response available
//   rsp_ready   consumer accepts the response
//   rsp_rdata   extended load data; 0 for stores and faults
//   rsp_err     request faulted (misaligned, out of range, illegal funct3)
// Parameters:
//   DEPTH_WORDS     number of 32-bit words, power of two (>= 2)
//   WAIT_CYCLES     extra cycles between accept and execution, 0..15
//   CLEAR_ON_RESET  1: reset zeroes the array; 0: contents survive reset
// -----------------------------------------------------------------------------
module data_memory_hs
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS    = 1024,
  parameter int WAIT_CYCLES    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDX_W    = word_idx_w(DEPTH_WORDS);
  localparam logic [29:0] WORD_LIM = 30'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;

  // Request fields captured at the accept edge.
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  // Response registers.
  logic        r_rsp_valid;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic             w_accept;
  logic             w_rsp_hs;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_old_word;
  logic [3:0]       w_be;
  logic [31:0]      w_wword;
  logic [31:0]      w_ld_data;
  logic             w_misalign;
  logic             w_illegal;
  logic             w_oor;
  logic             w_fault;
  logic             w_commit;

  assign w_accept   = req_valid && req_ready;
  // r_rsp_valid is only ever set while in RESP.
  assign w_rsp_hs   = r_rsp_valid && rsp_ready;

  assign w_idx      = r_addr[2 +: IDX_W];
  assign w_old_word = r_mem[w_idx];
  // Compare the full word address so aliasing addresses beyond the array fault.
  assign w_oor      = (r_addr[31:2] >= WORD_LIM);
  assign w_fault    = w_misalign || w_illegal || w_oor;
  assign w_commit   = (r_state == EXEC) && r_we && !w_fault;

  dmem_lane_align u_align (
    .i_we       (r_we),
    .i_funct3   (r_funct3),
    .i_lane     (r_addr[1:0]),
    .i_wdata    (r_wdata),
    .i_old_word (w_old_word),
    .o_be       (w_be),
    .o_wword    (w_wword),
    .o_rdata    (w_ld_data),
    .o_misalign (w_misalign),
    .o_illegal  (w_illegal)
  );

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    req_ready   = (r_state == IDLE) && !rst;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES > 0) begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end else begin
            w_state_nxt = EXEC;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = EXEC;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      EXEC: begin
        w_state_nxt = RESP;
      end
      RESP: begin
        if (w_rsp_hs) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Control and response registers. rsp_valid is registered one edge after
  // entering RESP so the response channel is driven straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rsp_valid <= (r_state == RESP) && !w_rsp_hs;
      if (r_state == EXEC) begin
        r_err   <= w_fault;
        r_rdata <= (w_fault || r_we) ? 32'd0 : w_ld_data;
      end
    end
  end

  // Request capture: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we     <= req_we;
      r_funct3 <= req_funct3;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end
  end

  // Storage array; a store commits on its EXEC edge only.
  generate
    if (CLEAR_ON_RESET != 0) begin : g_mem_clr
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= 32'd0;
        end else if (w_commit) begin
          r_mem[w_idx] <= w_wword;
        end
      end
    end else begin : g_mem_keep
      always_ff @(posedge clk) begin
        if (w_commit) r_mem[w_idx] <= w_wword;
      end
    end
  endgenerate

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
